counter_seq: RTL
================

Name: counter_seq

Overview:
Sequencing controller for a programmable modulo up-counter. It accepts a configuration through a valid/ready handshake: terminal value, prescale divisor, and one-shot or auto-reload mode. It runs the counter on a start command and supports pause, resume and abort. It reports terminal count as a single-cycle pulse and as a sticky done flag, which is cleared by an acknowledge. It sits between a control master (CPU register block or top-level FSM) and the counter datapath.

Parameters:
WIDTH, 4, counter width in bits; count runs 0..limit.
PRESC_W, 4, prescaler field width; one tick every presc+1 clocks.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
cfg_valid  in  1  configuration offer.
cfg_ready  out  1  configuration can be accepted.
cfg_limit  in  WIDTH  terminal value (inclusive).
cfg_presc  in  PRESC_W  prescale value.
cfg_reload  in  1  1 = auto-reload, 0 = one-shot.
start  in  1  start request; single-cycle or level.
pause  in  1  level; holds the counter while high.
abort  in  1  cancel the run; return to IDLE.
done_ack  in  1  clears done.
count  out  WIDTH  current count value.
busy  out  1  high in RUN or PAUSE.
tick  out  1  prescaler enable for this cycle (combinational from state and prescaler).
tc_pulse  out  1  registered; one cycle per terminal count.
done  out  1  sticky one-shot completion flag.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - count=0, prescaler counter=0.
  - limit register = all ones; presc register = 0; reload register = 0.
  - cfg_ready=1, busy=0, tick=0, tc_pulse=0, done=0.
- rst asserted mid-run returns every register to its reset value at the next edge.
- States (2-bit encoding): IDLE, RUN, PAUSE, DONE.
- Priority in any cycle: rst > abort > pause > tick.
- Config handshake:
  - cfg_ready=1 in IDLE and DONE, 0 in RUN and PAUSE.
  - Transfer occurs when cfg_valid && cfg_ready; the registers update at that edge.
- IDLE:
  - start -> RUN next cycle; count=0, prescaler counter=0.
  - If cfg transfer and start occur in the same cycle, the new configuration governs the run.
- RUN:
  - tick = (prescaler counter == presc).
  - On tick the prescaler counter goes to 0; otherwise it increments.
  - Latency: start sampled at edge N; first tick in cycle N+1+presc; count=1 visible after the following edge.
  - On tick with count != limit: count+1.
  - On tick with count == limit: count<=0 and tc_pulse=1 for exactly the next cycle. Then reload=1 stays in RUN; reload=0 goes to DONE and done<=1.
  - limit=0: every tick is terminal; count stays 0.
  - start while busy is ignored; no restart.
- PAUSE:
  - Entered from RUN when pause=1; count and prescaler counter are frozen and tick=0.
  - pause=0 -> RUN; the run resumes from the frozen prescaler phase.
  - pause in IDLE or DONE is ignored.
- abort in RUN or PAUSE:
  - -> IDLE next cycle; count=0, prescaler counter=0.
  - No tc_pulse; done is unchanged.
  - abort in the same cycle as a terminal tick: abort wins and no tc_pulse is produced.
- DONE:
  - count=0, busy=0.
  - done stays 1 until done_ack; done_ack -> IDLE with done=0.
  - start in DONE is ignored, including when it coincides with done_ack.
  - done_ack outside DONE is ignored.
- Arithmetic:
  - All increments wrap modulo 2^WIDTH or 2^PRESC_W, but wrap can only occur via the limit compare.
  - limit is unsigned.

Decomposition:
- Package counter_seq_pkg holds:
  - state typedef and encodings (IDLE=0, RUN=1, PAUSE=2, DONE=3);
  - default WIDTH and PRESC_W constants.
- One sub-module, mod_counter, holds the counter datapath:
  - inputs: clk, rst, en, clr, limit;
  - outputs: count, at_limit;
  - on en it counts 0..limit and wraps.
- counter_seq contains the FSM, the prescaler, the config registers and the flags.

Test Plan:
1. Reset then one-shot: limit=3, presc=0, reload=0, start -> count 1,2,3,0 on consecutive cycles; tc_pulse once; done=1; cfg_ready=1; busy=0.
2. Prescale and reload: limit=2, presc=2, reload=1 -> tick every 3rd cycle; count 0,1,2,0,...; tc_pulse every 9 cycles; done stays 0.
3. Pause: during the scenario 1 run, pause for 5 cycles at count=2 -> count holds 2 and tick=0; resume reaches limit with exactly one tc_pulse.
4. Abort on terminal tick: abort coincides with count==limit tick -> IDLE, count=0, no tc_pulse, done=0.
5. Handshakes: cfg offered in RUN -> cfg_ready=0 and no update. cfg and start in the same IDLE cycle -> the new limit is used. In DONE, start+done_ack -> IDLE, done=0, no run.
6. Mid-run reset: rst during RUN at count=2 -> all reset values next cycle; limit register back to 15.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter sequencing controller.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_PRESC_W = 4;

endpackage

// File: rtl/counter_seq_mod_counter.sv
// Modulo up-counter datapath: counts 0..limit on en, clr forces zero.
module mod_counter
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign at_limit = (count_q == limit);
    assign count    = count_q;

    // The only wrap path is the limit compare; the raw increment never overflows past limit.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = at_limit ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/counter_seq.sv
// Sequencing controller: config handshake, prescaler, run/pause/abort FSM and completion flags.
module counter_seq
    import counter_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_limit,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic               cfg_reload,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    input  logic               done_ack,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               tick,
    output logic               tc_pulse,
    output logic               done
);

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               reload_q, reload_d;
    logic               tc_pulse_q, tc_pulse_d;
    logic               done_q, done_d;
    logic               cnt_en, cnt_clr, at_limit;
    logic               cfg_xfer;

    assign tick     = (state_q == ST_RUN) && (presc_cnt_q == presc_q);
    assign cfg_xfer = cfg_valid && cfg_ready;
    assign tc_pulse = tc_pulse_q;
    assign done     = done_q;

    mod_counter #(.WIDTH(WIDTH)) u_mod_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .limit    (limit_q),
        .count    (count),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority inside RUN/PAUSE: abort, then pause, then the tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)                              state_d = ST_IDLE;
                else if (pause)                         state_d = ST_PAUSE;
                else if (tick && at_limit && !reload_q) state_d = ST_DONE;
            end
            ST_PAUSE: begin
                if (abort)       state_d = ST_IDLE;
                else if (!pause) state_d = ST_RUN;
            end
            ST_DONE:  if (done_ack) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
        busy      = (state_q == ST_RUN)  || (state_q == ST_PAUSE);
    end

    always_comb begin
        presc_cnt_d = presc_cnt_q;
        limit_d     = cfg_xfer ? cfg_limit  : limit_q;
        presc_d     = cfg_xfer ? cfg_presc  : presc_q;
        reload_d    = cfg_xfer ? cfg_reload : reload_q;
        tc_pulse_d  = 1'b0;
        done_d      = done_q;
        cnt_en      = 1'b0;
        cnt_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_clr     = 1'b1;
                    presc_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    cnt_clr     = 1'b1;
                    presc_cnt_d = '0;
                end else if (!pause) begin
                    if (tick) begin
                        presc_cnt_d = '0;
                        cnt_en      = 1'b1;
                        if (at_limit) begin
                            tc_pulse_d = 1'b1;
                            if (!reload_q) done_d = 1'b1;
                        end
                    end else begin
                        presc_cnt_d = presc_cnt_q + PRESC_W'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    cnt_clr     = 1'b1;
                    presc_cnt_d = '0;
                end
            end
            ST_DONE: begin
                if (done_ack) done_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_q <= '0;
            limit_q     <= '1;
            presc_q     <= '0;
            reload_q    <= 1'b0;
            tc_pulse_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            limit_q     <= limit_d;
            presc_q     <= presc_d;
            reload_q    <= reload_d;
            tc_pulse_q  <= tc_pulse_d;
            done_q      <= done_d;
        end
    end

endmodule
